// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// The checksum width is only used when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StCsum,
        StDone,
        StError
    } load_state_t;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CSUM_W         = 8;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into 32-bit little-endian words.
// word_ready_o marks the cycle the fourth byte of a word is pushed.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [31:0] shift_q;
    logic [1:0]  cnt_q;

    // The incoming byte lands in the top lane; after four pushes the first byte sits in [7:0].
    assign word_o       = {byte_i, shift_q[31:8]};
    assign word_ready_o = push_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (push_i) begin
            shift_q <= word_o;
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte frame into instruction memory, holding the CPU in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the data.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addwrite_o,
    output logic [31:0]       datowrite_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_rst_no
);

    load_state_t state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] len_full;
    logic        accept;
    logic        pack_clear;
    logic        pack_push;
    logic [31:0] pack_word;
    logic        word_ready;

    logic              ready_d, we_d, busy_d, done_d, err_d;
    logic [ADDR_W-1:0] addwrite_d;
    logic [31:0]       datowrite_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam load_state_t LastNext = StCsum;
    logic [CSUM_W-1:0] csum_q, csum_d;
`else
    localparam load_state_t LastNext = StDone;
`endif

    assign accept   = byte_valid_i && byte_ready_o;
    assign len_full = {byte_data_i, len_q[7:0]};

    imem_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (pack_clear),
        .push_i       (pack_push),
        .byte_i       (byte_data_i),
        .word_o       (pack_word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        pack_clear = 1'b0;
        pack_push  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d    = StLenLo;
                    len_d      = '0;
                    idx_d      = '0;
                    pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d   = {8'h00, byte_data_i};
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = LastNext;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    pack_push = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q + byte_data_i;
`endif
                    if (word_ready) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q + 16'd1 == len_q) ? LastNext : StData;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (byte_data_i == csum_q) ? StDone : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are all flop outputs.
    always_comb begin
        ready_d     = state_d inside {StLenLo, StLenHi, StData, StCsum};
        we_d        = (state_d == StWrite);
        busy_d      = !(state_d inside {StIdle, StDone, StError});
        done_d      = (state_d == StDone);
        err_d       = (state_d == StError);
        addwrite_d  = addwrite_o;
        datowrite_d = datowrite_o;
        if (state_q == StData && state_d == StWrite) begin
            addwrite_d  = idx_q[ADDR_W-1:0];
            datowrite_d = pack_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            len_q        <= '0;
            idx_q        <= '0;
            byte_ready_o <= 1'b0;
            we_o         <= 1'b0;
            addwrite_o   <= '0;
            datowrite_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            cpu_rst_no   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            byte_ready_o <= ready_d;
            we_o         <= we_d;
            addwrite_o   <= addwrite_d;
            datowrite_o  <= datowrite_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            err_o        <= err_d;
            cpu_rst_no   <= done_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a monitor checks each we_o pulse.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum frames.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] addwrite;
    logic [31:0]       datowrite;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_rst_n;

    int checks   = 0;
    int failures = 0;
    logic [ADDR_W+31:0] exp_q[$];

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .addwrite_o   (addwrite),
        .datowrite_o  (datowrite),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .cpu_rst_no   (cpu_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %08h expected no write",
                         addwrite, datowrite);
            end else begin
                check("write_addr", 64'(addwrite), 64'(exp_q[0][ADDR_W+31:32]));
                check("write_data", 64'(datowrite), 64'(exp_q[0][31:0]));
                void'(exp_q.pop_front());
            end
            check("ready_in_write", 64'(byte_ready), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: got ready %b expected 1 within 20 cycles", byte_ready);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t bytes, input bit gap);
        foreach (bytes[i]) send_byte(bytes[i], gap);
    endtask

    task automatic check_done(input string name);
        tick();
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd1);
        check({name, "_err"}, 64'(err), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        byte_q_t frame;
        byte_q_t head;
        byte_q_t tail;
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        head  = '{8'h02, 8'h00, 8'h13, 8'h05};
        tail  = '{8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'hE0);
        tail.push_back(8'hE0);
`endif

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst_addr", 64'(addwrite), 64'd0);
        check("rst_data", 64'(datowrite), 64'd0);
        rst_n = 1'b1;
        tick();

        // Normal back-to-back load.
        expect_write(10'd0, 32'h0010_0513);
        expect_write(10'd1, 32'h0020_0593);
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(byte_ready), 64'd1);
        send_frame(frame, 1'b0);
        check_done("normal");

        // Same frame with byte_valid toggling.
        expect_write(10'd0, 32'h0010_0513);
        expect_write(10'd1, 32'h0020_0593);
        pulse_start();
        send_frame(frame, 1'b1);
        check_done("gaps");

        // Restart from DONE clears status, then an empty frame.
        pulse_start();
        check("restart_done", 64'(done), 64'd0);
        check("restart_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
`else
        send_frame('{8'h00, 8'h00}, 1'b0);
`endif
        check_done("empty");

        // Oversize: N = 1025.
        pulse_start();
        send_frame('{8'h01, 8'h04}, 1'b0);
        tick();
        check("oversize_err", 64'(err), 64'd1);
        check("oversize_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("oversize_done", 64'(done), 64'd0);
        check("oversize_busy", 64'(busy), 64'd0);

        // Reset after six data bytes: only word 0 is written.
        expect_write(10'd0, 32'h0010_0513);
        pulse_start();
        send_frame('{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05}, 1'b0);
        rst_n = 1'b0;
        tick();
        check("midrst_ready", 64'(byte_ready), 64'd0);
        check("midrst_we", 64'(we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("midrst_addr", 64'(addwrite), 64'd0);
        check("midrst_data", 64'(datowrite), 64'd0);
        check("midrst_pending", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b1;
        tick();
        expect_write(10'd0, 32'h0010_0513);
        expect_write(10'd1, 32'h0020_0593);
        pulse_start();
        send_frame(frame, 1'b0);
        check_done("reload");

        // start_i during DATA is ignored.
        expect_write(10'd0, 32'h0010_0513);
        expect_write(10'd1, 32'h0020_0593);
        pulse_start();
        send_frame(head, 1'b0);
        pulse_start();
        check("ignored_start_busy", 64'(busy), 64'd1);
        send_frame(tail, 1'b0);
        check_done("ignored_start");

`ifdef IMEM_LOADER_CHECKSUM_EN
        expect_write(10'd0, 32'h0403_0201);
        pulse_start();
        send_frame('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 1'b0);
        check_done("csum_ok");

        expect_write(10'd0, 32'h0403_0201);
        pulse_start();
        send_frame('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B}, 1'b0);
        tick();
        check("csum_bad_err", 64'(err), 64'd1);
        check("csum_bad_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("csum_bad_done", 64'(done), 64'd0);
        check("csum_bad_pending", 64'(exp_q.size()), 64'd0);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
